// File: rtl/updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_p
// Purpose  : Parametrised registered up/down counter with a programmable
//            step, a parallel load, wrap or saturate behaviour at the range
//            bounds, and pulsed plus sticky overflow/underflow flags.
//            The count range is 0..MAX_VAL. In wrap mode the counter wraps
//            modulo MAX_VAL+1.
// Ports    : clk           rising-edge clock
//            rst           synchronous reset, active-high, overrides all
//            i_en          count enable (gates up/down only, not load)
//            i_up          count up by step (wins over i_down)
//            i_down        count down by step
//            i_load        parallel load of i_load_val (clamped to MAX_VAL)
//            i_load_val    value to load
//            i_step        step magnitude (clamped to MAX_VAL)
//            i_sat_mode    1 = saturate at bounds, 0 = wrap
//            i_clr_flags   clear sticky flags (a same-edge set wins)
//            o_count       registered count
//            o_ovf/o_unf   one-cycle pulses on an up/down bound crossing
//            o_ovf_sticky  latched o_ovf
//            o_unf_sticky  latched o_unf
//            o_at_max      count == MAX_VAL
//            o_at_zero     count == 0
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_p #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_step,
  input  logic             i_sat_mode,
  input  logic             i_clr_flags,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_ovf_sticky,
  output logic             o_unf_sticky,
  output logic             o_at_max,
  output logic             o_at_zero
);

  localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_RESET   = WIDTH'(RESET_VAL);
  // One extra bit so that count+step and the modulus never truncate.
  localparam logic [WIDTH:0]   c_MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   c_MOD     = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_ovf_sticky;
  logic             r_unf_sticky;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  assign w_step     = (i_step > c_MAX) ? c_MAX : i_step;
  assign w_load_val = (i_load_val > c_MAX) ? c_MAX : i_load_val;
  assign w_sum      = {1'b0, r_count} + {1'b0, w_step};

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (i_load) begin
      w_count_nxt = w_load_val;
    end else if (i_en && i_up) begin
      if (w_sum > c_MAX_EXT) begin
        if (i_sat_mode) begin
          w_count_nxt = c_MAX;
          // Holding at the top must not re-fire the pulse.
          w_ovf_nxt   = (r_count != c_MAX);
        end else begin
          w_count_nxt = WIDTH'(w_sum - c_MOD);
          w_ovf_nxt   = 1'b1;
        end
      end else begin
        w_count_nxt = w_sum[WIDTH-1:0];
      end
    end else if (i_en && i_down) begin
      if (w_step > r_count) begin
        if (i_sat_mode) begin
          w_count_nxt = '0;
          w_unf_nxt   = (r_count != '0);
        end else begin
          // count + modulus - step is always below the modulus here.
          w_count_nxt = WIDTH'({1'b0, r_count} + c_MOD - {1'b0, w_step});
          w_unf_nxt   = 1'b1;
        end
      end else begin
        w_count_nxt = r_count - w_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= c_RESET;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_ovf        <= w_ovf_nxt;
      r_unf        <= w_unf_nxt;
      // A new event on the same edge as a clear keeps the flag set.
      r_ovf_sticky <= w_ovf_nxt | (r_ovf_sticky & ~i_clr_flags);
      r_unf_sticky <= w_unf_nxt | (r_unf_sticky & ~i_clr_flags);
    end
  end

  assign o_count      = r_count;
  assign o_ovf        = r_ovf;
  assign o_unf        = r_unf;
  assign o_ovf_sticky = r_ovf_sticky;
  assign o_unf_sticky = r_unf_sticky;
  assign o_at_max     = (r_count == c_MAX);
  assign o_at_zero    = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_p
// Purpose  : Self-checking bench for updown_counter_p configured as a decade
//            counter (WIDTH=4, MAX_VAL=9, RESET_VAL=0). Directed scenarios
//            are followed by random traffic; an integer reference model
//            predicts count and flags after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter_p;

  localparam int WIDTH     = 4;
  localparam int MAX_VAL   = 9;
  localparam int RESET_VAL = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_en = 1'b0;
  logic             i_up = 1'b0;
  logic             i_down = 1'b0;
  logic             i_load = 1'b0;
  logic [WIDTH-1:0] i_load_val = '0;
  logic [WIDTH-1:0] i_step = '0;
  logic             i_sat_mode = 1'b0;
  logic             i_clr_flags = 1'b0;
  logic [WIDTH-1:0] o_count;
  logic             o_ovf;
  logic             o_unf;
  logic             o_ovf_sticky;
  logic             o_unf_sticky;
  logic             o_at_max;
  logic             o_at_zero;

  updown_counter_p #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .RESET_VAL(RESET_VAL)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_up        (i_up),
    .i_down      (i_down),
    .i_load      (i_load),
    .i_load_val  (i_load_val),
    .i_step      (i_step),
    .i_sat_mode  (i_sat_mode),
    .i_clr_flags (i_clr_flags),
    .o_count     (o_count),
    .o_ovf       (o_ovf),
    .o_unf       (o_unf),
    .o_ovf_sticky(o_ovf_sticky),
    .o_unf_sticky(o_unf_sticky),
    .o_at_max    (o_at_max),
    .o_at_zero   (o_at_zero)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (plain integers).
  int m_count = 0;
  int m_ovf   = 0;
  int m_unf   = 0;
  int m_ovs   = 0;
  int m_uns   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Predict the state after one edge from the arithmetic rules of the counter.
  task automatic model_edge(input int r, input int ld, input int lv, input int en,
                            input int up, input int dn, input int st,
                            input int sat, input int clr);
    int s;
    int n;
    if (r != 0) begin
      m_count = RESET_VAL; m_ovf = 0; m_unf = 0; m_ovs = 0; m_uns = 0;
      return;
    end
    m_ovf = 0;
    m_unf = 0;
    s = (st > MAX_VAL) ? MAX_VAL : st;
    if (ld != 0) begin
      m_count = (lv > MAX_VAL) ? MAX_VAL : lv;
    end else if (en != 0 && up != 0) begin
      n = m_count + s;
      if (n <= MAX_VAL) m_count = n;
      else if (sat != 0) begin
        m_ovf = (m_count < MAX_VAL) ? 1 : 0;
        m_count = MAX_VAL;
      end else begin
        m_count = n % (MAX_VAL + 1);
        m_ovf = 1;
      end
    end else if (en != 0 && dn != 0) begin
      n = m_count - s;
      if (n >= 0) m_count = n;
      else if (sat != 0) begin
        m_unf = (m_count > 0) ? 1 : 0;
        m_count = 0;
      end else begin
        m_count = n + MAX_VAL + 1;
        m_unf = 1;
      end
    end
    m_ovs = (m_ovf != 0 || (m_ovs != 0 && clr == 0)) ? 1 : 0;
    m_uns = (m_unf != 0 || (m_uns != 0 && clr == 0)) ? 1 : 0;
  endtask

  // Apply inputs away from the edge, clock once, then compare everything.
  task automatic cyc(input string tag, input int r, input int ld, input int lv,
                     input int en, input int up, input int dn, input int st,
                     input int sat, input int clr);
    @(negedge clk);
    rst = r[0]; i_load = ld[0]; i_load_val = lv[WIDTH-1:0]; i_en = en[0];
    i_up = up[0]; i_down = dn[0]; i_step = st[WIDTH-1:0];
    i_sat_mode = sat[0]; i_clr_flags = clr[0];
    @(posedge clk);
    #1;
    model_edge(r, ld, lv & 15, en, up, dn, st & 15, sat, clr);
    check({tag, ".count"},  int'(o_count),      m_count);
    check({tag, ".ovf"},    int'(o_ovf),        m_ovf);
    check({tag, ".unf"},    int'(o_unf),        m_unf);
    check({tag, ".ovs"},    int'(o_ovf_sticky), m_ovs);
    check({tag, ".uns"},    int'(o_unf_sticky), m_uns);
    check({tag, ".atmax"},  int'(o_at_max),     (m_count == MAX_VAL) ? 1 : 0);
    check({tag, ".atzero"}, int'(o_at_zero),    (m_count == 0) ? 1 : 0);
  endtask

  initial begin
    // Reset and load, including the clamp.
    //      tag        rst ld lv en up dn st sat clr
    cyc("reset",        1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.const", int'(o_count), 0);
    cyc("load7",        0, 1, 7, 0, 0, 0, 0, 0, 0);
    check("load7.const", int'(o_count), 7);
    cyc("load15",       0, 1, 15, 0, 0, 0, 0, 0, 0);
    check("load15.const", int'(o_count), 9);

    // Decade wrap up.
    cyc("ld8",          0, 1, 8, 0, 0, 0, 0, 0, 0);
    cyc("up8to9",       0, 0, 0, 1, 1, 0, 1, 0, 0);
    cyc("up9to0",       0, 0, 0, 1, 1, 0, 1, 0, 0);
    check("wrap.ovf.const", int'(o_ovf), 1);
    cyc("idle_after",   0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("wrap.pulse_end", int'(o_ovf), 0);
    cyc("ld8b",         0, 1, 8, 0, 0, 0, 0, 0, 0);
    cyc("up8s3",        0, 0, 0, 1, 1, 0, 3, 0, 0);
    check("up8s3.const", int'(o_count), 1);

    // Wrap down.
    cyc("dn1s3",        0, 0, 0, 1, 0, 1, 3, 0, 0);
    check("dn1s3.const", int'(o_count), 8);
    cyc("ld0",          0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("dn0s1",        0, 0, 0, 1, 0, 1, 1, 0, 0);
    check("dn0s1.const", int'(o_count), 9);

    // Saturate at both bounds; repeated attempts give no new pulse.
    cyc("ld7",          0, 1, 7, 0, 0, 0, 0, 1, 0);
    cyc("sat_up1",      0, 0, 0, 1, 1, 0, 5, 1, 0);
    cyc("sat_up2",      0, 0, 0, 1, 1, 0, 5, 1, 0);
    cyc("ld2",          0, 1, 2, 0, 0, 0, 0, 1, 0);
    cyc("sat_dn1",      0, 0, 0, 1, 0, 1, 5, 1, 0);
    cyc("sat_dn2",      0, 0, 0, 1, 0, 1, 5, 1, 0);

    // Priority, enable, zero step, oversized step.
    cyc("ld4",          0, 1, 4, 0, 0, 0, 0, 0, 0);
    cyc("updn",         0, 0, 0, 1, 1, 1, 2, 0, 0);
    check("updn.const", int'(o_count), 6);
    cyc("en0",          0, 0, 0, 0, 1, 0, 2, 0, 0);
    cyc("ld_en0",       0, 1, 3, 0, 1, 0, 2, 0, 0);
    cyc("step0",        0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc("step15",       0, 0, 0, 1, 1, 0, 15, 0, 0);

    // Sticky set wins over clear; clear alone then drops it.
    cyc("clr",          0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("ld0b",         0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("unf_clr",      0, 0, 0, 1, 0, 1, 1, 0, 1);
    check("unf_clr.const", int'(o_unf_sticky), 1);
    cyc("clr_only",     0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("clr_only.const", int'(o_unf_sticky), 0);

    // Mid-count reset then resume.
    cyc("ld5",          0, 1, 5, 0, 0, 0, 0, 0, 0);
    cyc("midrst",       1, 0, 0, 1, 1, 0, 1, 0, 0);
    cyc("resume",       0, 0, 0, 1, 1, 0, 1, 0, 0);
    check("resume.const", int'(o_count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          ($urandom_range(0, 39) == 0) ? 1 : 0,
          ($urandom_range(0, 9) == 0) ? 1 : 0,
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 4) != 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)),
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_counter_p.md
Name: updown_counter_p

Overview:
- Parametrised registered up/down counter. Successor to the team's 4-bit increment/decrement block.
- Adds over the earlier block: configurable width and modulus, programmable step, parallel load, wrap or saturate mode, and terminal/overflow flags.
- Used as a general event/position counter (decade counters, pointer counters, timers) in the same datapath family.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX_VAL, 2**WIDTH-1, highest legal count; the count range is 0..MAX_VAL. Must be ≤ 2**WIDTH-1.
- RESET_VAL, 0, count value after reset. Must be ≤ MAX_VAL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; gates up/down only, not load.
- up  input  1  count up by step.
- down  input  1  count down by step.
- load  input  1  parallel load of load_val.
- load_val  input  WIDTH  value to load.
- step  input  WIDTH  increment/decrement magnitude.
- sat_mode  input  1  1 = saturate at bounds; 0 = wrap modulo MAX_VAL+1.
- clr_flags  input  1  clear sticky flags.
- count  output  WIDTH  registered count.
- ovf  output  1  registered one-cycle pulse: up-count crossed MAX_VAL.
- unf  output  1  registered one-cycle pulse: down-count crossed 0.
- ovf_sticky  output  1  latched ovf.
- unf_sticky  output  1  latched unf.
- at_max  output  1  combinational: count == MAX_VAL.
- at_zero  output  1  combinational: count == 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=RESET_VAL; ovf=unf=0; ovf_sticky=unf_sticky=0.
  - rst overrides every other input.
- Priority per edge: rst > load > (en & up) > (en & down) > hold.
  - up=down=1 with en=1: count up (up has priority, same as the earlier block).
- Load:
  - count <= min(load_val, MAX_VAL).
  - ovf=unf=0 that cycle; load is independent of en.
- Effective step: s = min(step, MAX_VAL). s=0 holds count; no flag.
- Arithmetic is done in WIDTH+1 bits; no intermediate truncation.
- Up, with n = count + s:
  - n ≤ MAX_VAL: count <= n.
  - n > MAX_VAL, wrap mode: count <= n - (MAX_VAL+1); ovf=1.
  - n > MAX_VAL, saturate mode: count <= MAX_VAL; ovf=1 only if count was < MAX_VAL before the edge. A held count at MAX_VAL produces no repeated ovf.
- Down:
  - s ≤ count: count <= count - s.
  - s > count, wrap mode: count <= count + (MAX_VAL+1) - s; unf=1.
  - s > count, saturate mode: count <= 0; unf=1 only if count was > 0 before the edge.
- Latency:
  - count, ovf and unf update on the same edge, so the pulse coincides with the post-wrap count.
  - ovf/unf are 0 on every cycle without a crossing.
- Sticky flags:
  - Set on the edge where ovf/unf is generated; cleared by clr_flags.
  - Set wins over clear in the same cycle.
  - Unaffected by load and en.
- sat_mode may change on any cycle; it takes effect on that edge.
- Mid-operation reset is valid on any cycle; the next cycle starts from RESET_VAL with all flags clear.
- No X propagation: all registers have defined reset values. Outputs are only the registered count/flags plus the two compare decodes.

Test Plan:
- Reset/load (WIDTH=4, MAX_VAL=9, RESET_VAL=0): rst=1 -> count=0, all flags 0. load=1, load_val=7 -> count=7. load_val=15 -> count=9 (clamped).
- Decade wrap up: count=8, step=1, up, en, sat_mode=0 -> count 9 (at_max=1), then 0 with ovf=1 for exactly one cycle and ovf_sticky=1. step=3 from 8 -> count=1, ovf=1.
- Wrap down: count=1, step=3, down -> count=8, unf=1. count=0, step=1 -> count=9, unf=1.
- Saturate: sat_mode=1, count=7, step=5, up -> count=9, ovf=1. A further up -> count=9, ovf=0. Same at 0 going down: first edge unf=1, repeat unf=0.
- Priority/enable: up=down=1, en=1, count=4, step=2 -> count=6. en=0 with up=1 -> hold. load=1 with en=0 -> loads. step=0 -> hold, no flags.
- Flags/reset: generate unf and assert clr_flags on the same edge -> unf_sticky=1; clr_flags alone next cycle -> 0. rst mid-count at count=5 -> count=0, stickies 0, and counting resumes from 0 the following cycle.
